// File: rtl/ram_dma.sv
// Word-by-word RAM-to-RAM copy engine: reads one word per cycle and writes it back one cycle later.
// Optional macro RAM_DMA_FILL_EN adds a constant-fill mode (fill_i / fill_data_i).
module ram_dma #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] src_addr_i,
  input  logic [AW-1:0] dst_addr_i,
  input  logic [AW:0]   len_i,
`ifdef RAM_DMA_FILL_EN
  input  logic          fill_i,
  input  logic [DW-1:0] fill_data_i,
`endif
  output logic          busy_o,
  output logic          done_o,
  output logic          mem_ren_o,
  output logic [AW-1:0] mem_r_addr_o,
  input  logic [DW-1:0] mem_r_data_i,
  output logic          mem_wen_o,
  output logic [AW-1:0] mem_w_addr_o,
  output logic [DW-1:0] mem_w_data_o
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t        state;
  logic [AW:0]   cnt;
  logic [AW-1:0] wptr;
  logic          fill_sel;

`ifdef RAM_DMA_FILL_EN
  logic          fill_q;
  logic [DW-1:0] fill_data_q;

  assign fill_sel = fill_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else if (state == IDLE && start_i) begin
      fill_q      <= fill_i;
      fill_data_q <= fill_data_i;
    end else if (state == DONE) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end
  end

  assign mem_w_data_o = !mem_wen_o ? '0 : (fill_q ? fill_data_q : mem_r_data_i);
`else
  localparam logic fill_q = 1'b0;

  assign fill_sel     = 1'b0;
  assign mem_w_data_o = mem_wen_o ? mem_r_data_i : '0;
`endif

  // Read issued in cycle k returns in cycle k+1, where it is written straight through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wptr         <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      mem_ren_o    <= 1'b0;
      mem_r_addr_o <= '0;
      mem_wen_o    <= 1'b0;
      mem_w_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state  <= XFER;
              busy_o <= 1'b1;
              cnt    <= len_i - 1'b1;
              if (fill_sel) begin
                mem_wen_o    <= 1'b1;
                mem_w_addr_o <= dst_addr_i;
              end else begin
                mem_ren_o    <= 1'b1;
                mem_r_addr_o <= src_addr_i;
                wptr         <= dst_addr_i;
              end
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        XFER: begin
          if (fill_q) begin
            if (cnt != '0) begin
              cnt          <= cnt - 1'b1;
              mem_w_addr_o <= mem_w_addr_o + 1'b1;
            end else begin
              state        <= DONE;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
              mem_wen_o    <= 1'b0;
              mem_w_addr_o <= '0;
            end
          end else begin
            mem_wen_o    <= 1'b1;
            mem_w_addr_o <= wptr;
            wptr         <= wptr + 1'b1;
            if (cnt != '0) begin
              cnt          <= cnt - 1'b1;
              mem_r_addr_o <= mem_r_addr_o + 1'b1;
            end else begin
              state        <= DRAIN;
              mem_ren_o    <= 1'b0;
              mem_r_addr_o <= '0;
            end
          end
        end
        DRAIN: begin
          state        <= DONE;
          busy_o       <= 1'b0;
          done_o       <= 1'b1;
          mem_wen_o    <= 1'b0;
          mem_w_addr_o <= '0;
          wptr         <= '0;
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          cnt    <= '0;
          wptr   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// Scoreboard bench for ram_dma: behavioural RAM, sequential-copy reference model, queue-based monitor.
module tb_ram_dma;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start_i;
  logic [AW-1:0] src_addr_i, dst_addr_i;
  logic [AW:0]   len_i;
  logic          busy_o, done_o, mem_ren_o, mem_wen_o;
  logic [AW-1:0] mem_r_addr_o, mem_w_addr_o;
  logic [DW-1:0] mem_r_data_i, mem_w_data_o;
`ifdef RAM_DMA_FILL_EN
  logic          fill_i;
  logic [DW-1:0] fill_data_i;
`endif

  always #5 clk = ~clk;

  ram_dma #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
`ifdef RAM_DMA_FILL_EN
    .fill_i(fill_i), .fill_data_i(fill_data_i),
`endif
    .busy_o(busy_o), .done_o(done_o),
    .mem_ren_o(mem_ren_o), .mem_r_addr_o(mem_r_addr_o), .mem_r_data_i(mem_r_data_i),
    .mem_wen_o(mem_wen_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o)
  );

  // Synchronous RAM, write-first on a read/write address collision, plus a backdoor preload port.
  logic [DW-1:0] ram [N];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_a;
  logic [DW-1:0] bd_d;

  always @(posedge clk) begin
    if (bd_we) ram[bd_a] <= bd_d;
    if (mem_wen_o) ram[mem_w_addr_o] <= mem_w_data_o;
    mem_r_data_i <= (mem_wen_o && mem_w_addr_o == mem_r_addr_o) ? mem_w_data_o : ram[mem_r_addr_o];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [DW-1:0] model [N];
  logic [AW-1:0] exp_rd [$];
  wr_t           exp_wr [$];
  int            errors = 0;
  int            checks = 0;
  int            busy_cnt = 0;
  int            done_cnt = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected read/write streams whenever the DUT drives its RAM ports.
  logic [AW-1:0] m_ra;
  wr_t           m_w;
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_ren_o) begin
        if (exp_rd.size() == 0) chk(1'b0, "unexpected_read", 64'(mem_r_addr_o), 64'd0);
        else begin
          m_ra = exp_rd.pop_front();
          chk(mem_r_addr_o == m_ra, "read_addr", 64'(mem_r_addr_o), 64'(m_ra));
        end
      end else
        chk(mem_r_addr_o == '0, "idle_read_addr", 64'(mem_r_addr_o), 64'd0);
      if (mem_wen_o) begin
        if (exp_wr.size() == 0) chk(1'b0, "unexpected_write", 64'(mem_w_addr_o), 64'd0);
        else begin
          m_w = exp_wr.pop_front();
          chk(mem_w_addr_o == m_w.a, "write_addr", 64'(mem_w_addr_o), 64'(m_w.a));
          chk(mem_w_data_o == m_w.d, "write_data", 64'(mem_w_data_o), 64'(m_w.d));
        end
      end else
        chk(mem_w_addr_o == '0 && mem_w_data_o == '0, "idle_write_port",
            {20'd0, mem_w_addr_o, mem_w_data_o}, 64'd0);
      if (busy_o) busy_cnt++;
      if (done_o) done_cnt++;
    end
  end

  task automatic check_idle(input string tag);
    chk(busy_o == 1'b0, {tag, "_busy"}, 64'(busy_o), 64'd0);
    chk(done_o == 1'b0, {tag, "_done"}, 64'(done_o), 64'd0);
    chk(mem_ren_o == 1'b0, {tag, "_ren"}, 64'(mem_ren_o), 64'd0);
    chk(mem_wen_o == 1'b0, {tag, "_wen"}, 64'(mem_wen_o), 64'd0);
    chk(mem_r_addr_o == '0, {tag, "_raddr"}, 64'(mem_r_addr_o), 64'd0);
    chk(mem_w_addr_o == '0, {tag, "_waddr"}, 64'(mem_w_addr_o), 64'd0);
    chk(mem_w_data_o == '0, {tag, "_wdata"}, 64'(mem_w_data_o), 64'd0);
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== model[i]) bad++;
    chk(bad == 0, {tag, "_mem_image"}, 64'(bad), 64'd0);
    if (bad != 0) for (int i = 0; i < N; i++) model[i] = ram[i];
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bd_a = a; bd_d = v; bd_we = 1'b1; model[a] = v;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic drive_ops(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                           input bit fill, input logic [DW-1:0] fd);
    src_addr_i = s; dst_addr_i = d; len_i = (AW+1)'(n);
`ifdef RAM_DMA_FILL_EN
    fill_i = fill; fill_data_i = fd;
`endif
  endtask

  // Reference: a sequential ascending copy (or fill) of n words, pushed as expected port traffic.
  task automatic xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                      input bit fill, input logic [DW-1:0] fd, input string tag);
    int lat, exp_lat;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] v;
    for (int k = 0; k < n; k++) begin
      ra = s + AW'(k);
      wa = d + AW'(k);
      if (!fill) exp_rd.push_back(ra);
      v = fill ? fd : model[ra];
      model[wa] = v;
      exp_wr.push_back('{a: wa, d: v});
    end
    exp_lat = (n == 0) ? 0 : (fill ? n : n + 1);
    busy_cnt = 0; done_cnt = 0;
    drive_ops(s, d, n, fill, fd);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    drive_ops(AW'($urandom), AW'($urandom), int'($urandom_range(0, N)), 1'($urandom), $urandom);
    lat = 0;
    while (!done_o && lat < n + 8) begin
      start_i = (lat == 2) && busy_o;
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    chk(done_o, {tag, "_done_seen"}, 64'(done_o), 64'd1);
    chk(lat == exp_lat, {tag, "_done_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    @(negedge clk);
    chk(done_cnt == 1, {tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk(busy_cnt == exp_lat, {tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    chk(exp_rd.size() == 0, {tag, "_reads_missing"}, 64'(exp_rd.size()), 64'd0);
    chk(exp_wr.size() == 0, {tag, "_writes_missing"}, 64'(exp_wr.size()), 64'd0);
    check_mem(tag);
  endtask

  // Reset asserted during the third XFER cycle of a len=8 copy: 3 reads, 2 writes, no done.
  task automatic reset_mid(input logic [AW-1:0] s, input logic [AW-1:0] d);
    logic [DW-1:0] v;
    for (int k = 0; k < 3; k++) exp_rd.push_back(s + AW'(k));
    for (int k = 0; k < 2; k++) begin
      v = model[s + AW'(k)];
      model[d + AW'(k)] = v;
      exp_wr.push_back('{a: d + AW'(k), d: v});
    end
    busy_cnt = 0; done_cnt = 0;
    drive_ops(s, d, 8, 1'b0, '0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("abort");
    repeat (3) @(negedge clk);
    chk(done_cnt == 0, "abort_no_done", 64'(done_cnt), 64'd0);
    chk(exp_rd.size() == 0 && exp_wr.size() == 0, "abort_traffic",
        64'(exp_rd.size() + exp_wr.size()), 64'd0);
    check_mem("abort");
  endtask

  initial begin
    logic [AW-1:0] s, d;
    int n;
    bit f;
    rst = 1'b0; start_i = 1'b0;
    drive_ops('0, '0, 0, 1'b0, '0);
    for (int i = 0; i < N; i++) begin
      bd_a = AW'(i); bd_d = $urandom; bd_we = 1'b1; model[i] = bd_d;
      @(negedge clk);
    end
    bd_we = 1'b0;
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) poke(AW'(12'h010 + i), 32'hA0 + i);
    xfer(12'h010, 12'h100, 4, 1'b0, '0, "basic");
    xfer(AW'($urandom), AW'($urandom), 0, 1'b0, '0, "len0");
    xfer(12'hFFE, 12'h002, 4, 1'b0, '0, "wrap");
    poke(12'h020, 32'h5);
    xfer(12'h020, 12'h021, 3, 1'b0, '0, "overlap");
    chk(ram[12'h023] == 32'h5, "overlap_last_word", 64'(ram[12'h023]), 64'h5);
    reset_mid(12'h300, 12'h500);
    xfer(12'h300, 12'h500, 8, 1'b0, '0, "after_abort");
`ifdef RAM_DMA_FILL_EN
    xfer(AW'($urandom), 12'h040, 3, 1'b1, 32'hDEADBEEF, "fill");
`endif
    xfer(AW'($urandom), AW'($urandom), N, 1'b0, '0, "full");
    for (int t = 0; t < 25; t++) begin
      s = AW'($urandom);
      d = ($urandom_range(0, 2) == 0) ? s + AW'($urandom_range(0, 5)) : AW'($urandom);
      n = int'($urandom_range(0, 40));
      f = 1'b0;
`ifdef RAM_DMA_FILL_EN
      f = 1'($urandom);
`endif
      xfer(s, d, n, f, $urandom, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_dma.md
RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 The block SHALL provide parameter DW, default 32, memory word width in bits.
REQ-002 The block SHALL provide parameter AW, default 12, memory word-address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start_i, input, 1 bit: request to begin a transfer.
REQ-006 The block SHALL have ports src_addr_i and dst_addr_i, inputs, AW bits each: first source word and first destination word.
REQ-007 The block SHALL have port len_i, input, AW+1 bits: transfer length in words, range 0..2^AW.
REQ-008 The block SHALL have port busy_o, output, 1 bit: transfer in progress.
REQ-009 The block SHALL have port done_o, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have ports mem_ren_o (output, 1 bit) and mem_r_addr_o (output, AW bits): RAM read port request.
REQ-011 The block SHALL have port mem_r_data_i, input, DW bits: RAM read data, valid one cycle after the read request.
REQ-012 The block SHALL have ports mem_wen_o (output, 1 bit), mem_w_addr_o (output, AW bits) and mem_w_data_o (output, DW bits): RAM write port.

Function
REQ-013 The block SHALL implement the FSM states IDLE, XFER, DRAIN and DONE.
REQ-014 In IDLE, start_i=1 SHALL register src, dst and len at that edge; the FSM SHALL go to XFER if len>0, else to DONE.
REQ-015 In XFER, for k=0..len-1, cycle k SHALL drive mem_ren_o=1 and mem_r_addr_o=src+k (mod 2^AW); after cycle len-1 the FSM SHALL go to DRAIN.
REQ-016 Each cycle k+1 (in XFER or DRAIN) SHALL drive mem_wen_o=1, mem_w_addr_o=dst+k (mod 2^AW) and mem_w_data_o=mem_r_data_i, giving throughput of one word per cycle.
REQ-017 DRAIN SHALL last exactly one cycle (final write), then the FSM SHALL go to DONE.
REQ-018 DONE SHALL last one cycle with done_o=1, then the FSM SHALL return to IDLE.
REQ-019 busy_o SHALL be 1 exactly in XFER and DRAIN, so a copy of len>0 has busy_o high for len+1 cycles.
REQ-020 start_i SHALL be ignored outside IDLE, and the input operands SHALL be sampled only at acceptance.
REQ-021 len=0 SHALL produce no memory access and SHALL give done_o one cycle after acceptance.
REQ-022 Address counters SHALL wrap modulo 2^AW, and len=2^AW SHALL copy every word exactly once.
REQ-023 Overlapping copies SHALL give results equal to a sequential word-by-word ascending copy, relying on the RAM's new-data-on-collision read; the block SHALL add no hazard logic.
REQ-024 Outside the active cycles, mem_ren_o and mem_wen_o SHALL be 0, and the address and data outputs SHALL hold 0.

Reset
REQ-025 While rst=0 at a clock edge, the FSM SHALL go to IDLE and all outputs and internal counters SHALL be 0 in the next cycle.
REQ-026 A reset during XFER or DRAIN SHALL abort the transfer, leave already-written words intact, and produce no done_o.

Configuration
REQ-027 The macro RAM_DMA_FILL_EN SHALL, when defined, add inputs fill_i (1 bit) and fill_data_i (DW bits), sampled at acceptance.
REQ-028 With RAM_DMA_FILL_EN defined and fill_i=1, cycles k=0..len-1 SHALL write fill_data_i to dst+k with mem_ren_o=0, skip DRAIN, and busy_o SHALL be high for len cycles.
REQ-029 Without RAM_DMA_FILL_EN, the ports SHALL be absent and the block SHALL be copy-only with identical copy timing.

Verification
REQ-030 Scenario: RAM[0x010..0x013]=A0..A3, start with src=0x010, dst=0x100, len=4 -> RAM[0x100..0x103]=A0..A3, busy_o high for 5 cycles, then one done_o pulse.
REQ-031 Scenario: len=0 -> no mem_ren_o or mem_wen_o, and done_o in the cycle after acceptance.
REQ-032 Scenario: src=0xFFE, dst=0x002, len=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001 in order, writes 0x002..0x005.
REQ-033 Scenario: RAM[0x20]=0x5, src=0x20, dst=0x21, len=3 -> RAM[0x21..0x23]=0x5, 0x5, 0x5 (forward-overlap semantics).
REQ-034 Scenario: rst=0 on the third XFER cycle of a len=8 copy -> exactly 2 words written, no done_o, all outputs 0, and a following start accepted normally.
REQ-035 Scenario (RAM_DMA_FILL_EN): fill_i=1, fill_data_i=0xDEADBEEF, dst=0x040, len=3 -> RAM[0x040..0x042]=0xDEADBEEF, zero reads, busy_o high for 3 cycles.
